// File: rtl/ex_stage_if.sv
// Bundle between the ID/EX register, the execute stage, the EX/MEM register and MEM/WB forwarding.
interface ex_stage_if;
    logic [1:0]  ALUOp_i;
    logic        ALUSrc_i;
    logic        RegWrite_i;
    logic        MemtoReg_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [31:0] imm_i;
    logic [9:0]  funct_i;
    logic [4:0]  RS1addr_i;
    logic [4:0]  RS2addr_i;
    logic [4:0]  RDaddr_i;
    logic        MEMWB_RegWrite_i;
    logic [4:0]  MEMWB_RDaddr_i;
    logic [31:0] MEMWB_data_i;
    logic        RegWrite_o;
    logic        MemtoReg_o;
    logic        MemRead_o;
    logic        MemWrite_o;
    logic [31:0] ALUResult_o;
    logic [31:0] MemData_o;
    logic [4:0]  RDaddr_o;
    logic        stall_o;

    modport slave (
        input  ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
               data1_i, data2_i, imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
               MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i,
        output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
               ALUResult_o, MemData_o, RDaddr_o, stall_o
    );

    modport master (
        output ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
               data1_i, data2_i, imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
               MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i,
        input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
               ALUResult_o, MemData_o, RDaddr_o, stall_o
    );
endinterface

// File: rtl/ex_stage.sv
// RISC-V execute stage: operand forwarding, ALU, iterative byte-serial multiplier and the EX/MEM register.
module ex_stage (
    input  logic      clk_i,
    input  logic      rst_i,
    ex_stage_if.slave ex_bus
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REGW  = 5;
    localparam int unsigned SHW   = 5;
    localparam int unsigned BYTEW = 8;
    localparam int unsigned CNTW  = 2;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_ITYPE = 2'b11;

    localparam logic [9:0] F_AND = 10'b0000000_111;
    localparam logic [9:0] F_XOR = 10'b0000000_100;
    localparam logic [9:0] F_SLL = 10'b0000000_001;
    localparam logic [9:0] F_ADD = 10'b0000000_000;
    localparam logic [9:0] F_SUB = 10'b0100000_000;
    localparam logic [9:0] F_MUL = 10'b0000001_000;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SRAI = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [CNTW-1:0] cnt_q;
    logic [XLEN-1:0] mul_a_q;
    logic [XLEN-1:0] mul_b_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] acc_d;

    logic            regwrite_q;
    logic            memtoreg_q;
    logic            memread_q;
    logic            memwrite_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] memdata_q;
    logic [REGW-1:0] rd_q;

    logic            exmem_hit_a;
    logic            exmem_hit_b;
    logic            memwb_hit_a;
    logic            memwb_hit_b;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            is_mul;
    logic            stall;
    logic [BYTEW-1:0] mul_byte;
    logic [SHW-1:0]   mul_shamt;

    // Forwarding: the instruction just retired into EX/MEM wins over MEM/WB
    always_comb begin
        exmem_hit_a = regwrite_q && (rd_q != '0) && (rd_q == ex_bus.RS1addr_i);
        exmem_hit_b = regwrite_q && (rd_q != '0) && (rd_q == ex_bus.RS2addr_i);
        memwb_hit_a = ex_bus.MEMWB_RegWrite_i && (ex_bus.MEMWB_RDaddr_i != '0)
                      && (ex_bus.MEMWB_RDaddr_i == ex_bus.RS1addr_i);
        memwb_hit_b = ex_bus.MEMWB_RegWrite_i && (ex_bus.MEMWB_RDaddr_i != '0)
                      && (ex_bus.MEMWB_RDaddr_i == ex_bus.RS2addr_i);
        fwd_a = exmem_hit_a ? result_q : (memwb_hit_a ? ex_bus.MEMWB_data_i : ex_bus.data1_i);
        fwd_b = exmem_hit_b ? result_q : (memwb_hit_b ? ex_bus.MEMWB_data_i : ex_bus.data2_i);
        op_b  = ex_bus.ALUSrc_i ? ex_bus.imm_i : fwd_b;
    end

    // Single-cycle ALU; mul is produced by the iterative path instead
    always_comb begin
        alu_result = '0;
        case (ex_bus.ALUOp_i)
            OP_ADD: alu_result = fwd_a + op_b;
            OP_RTYPE: begin
                case (ex_bus.funct_i)
                    F_AND:   alu_result = fwd_a & op_b;
                    F_XOR:   alu_result = fwd_a ^ op_b;
                    F_SLL:   alu_result = fwd_a << op_b[SHW-1:0];
                    F_ADD:   alu_result = fwd_a + op_b;
                    F_SUB:   alu_result = fwd_a - op_b;
                    default: alu_result = '0;
                endcase
            end
            OP_ITYPE: begin
                case (ex_bus.funct_i[2:0])
                    F3_ADDI: alu_result = fwd_a + op_b;
                    F3_SRAI: alu_result = XLEN'($signed(fwd_a) >>> ex_bus.imm_i[SHW-1:0]);
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    // One byte of B per BUSY cycle, partial product aligned to that byte
    always_comb begin
        mul_shamt = {cnt_q, 3'b000};
        mul_byte  = mul_b_q[mul_shamt +: BYTEW];
        acc_d     = acc_q + ((mul_a_q * XLEN'(mul_byte)) << mul_shamt);
    end

    // Stall is forced low during reset even if a mul is being held upstream
    always_comb begin
        is_mul = (ex_bus.ALUOp_i == OP_RTYPE) && (ex_bus.funct_i == F_MUL);
        stall  = rst_i && (((state_q == ST_IDLE) && is_mul) || (state_q == ST_BUSY));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            acc_q      <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            result_q   <= '0;
            memdata_q  <= '0;
            rd_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_mul) begin
                        mul_a_q <= fwd_a;
                        mul_b_q <= op_b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(3)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            // EX/MEM: bubble while stalled, otherwise the instruction in EX
            if (stall) begin
                regwrite_q <= 1'b0;
                memtoreg_q <= 1'b0;
                memread_q  <= 1'b0;
                memwrite_q <= 1'b0;
                result_q   <= '0;
                memdata_q  <= '0;
                rd_q       <= '0;
            end else begin
                regwrite_q <= ex_bus.RegWrite_i;
                memtoreg_q <= ex_bus.MemtoReg_i;
                memread_q  <= ex_bus.MemRead_i;
                memwrite_q <= ex_bus.MemWrite_i;
                result_q   <= (state_q == ST_DONE) ? acc_q : alu_result;
                memdata_q  <= fwd_b;
                rd_q       <= ex_bus.RDaddr_i;
            end
        end
    end

    assign ex_bus.RegWrite_o  = regwrite_q;
    assign ex_bus.MemtoReg_o  = memtoreg_q;
    assign ex_bus.MemRead_o   = memread_q;
    assign ex_bus.MemWrite_o  = memwrite_q;
    assign ex_bus.ALUResult_o = result_q;
    assign ex_bus.MemData_o   = memdata_q;
    assign ex_bus.RDaddr_o    = rd_q;
    assign ex_bus.stall_o     = stall;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RISC-V pipeline. It sits directly downstream of the ID/EX pipeline register and consumes that register's outputs. It resolves RS1/RS2 forwarding from EX/MEM and MEM/WB, executes the ALU operation, and runs multi-cycle `mul` on an iterative multiplier. It drives the EX/MEM pipeline register and raises `stall_o` to freeze IF, ID and ID/EX while a multiply is in flight.

## Interface
Parameters:
- none

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `ALUOp_i`  in  2  from ID/EX: 00 = add (load/store), 10 = R-type, 11 = I-type; 01 is reserved, result 0.
- `ALUSrc_i`  in  1  1 selects `imm_i` as operand B.
- `RegWrite_i`, `MemtoReg_i`, `MemRead_i`, `MemWrite_i`  in  1 each  control bits from ID/EX.
- `data1_i`, `data2_i`, `imm_i`  in  32  rs1 data, rs2 data, sign-extended immediate.
- `funct_i`  in  10  {funct7, funct3}.
- `RS1addr_i`, `RS2addr_i`, `RDaddr_i`  in  5  register addresses.
- `MEMWB_RegWrite_i`  in  1  MEM/WB write enable.
- `MEMWB_RDaddr_i`  in  5  MEM/WB destination register.
- `MEMWB_data_i`  in  32  final writeback value from MEM/WB.
- `RegWrite_o`, `MemtoReg_o`, `MemRead_o`, `MemWrite_o`  out  1 each  EX/MEM control bits.
- `ALUResult_o`  out  32  EX/MEM result.
- `MemData_o`  out  32  EX/MEM store data, which is forwarded rs2.
- `RDaddr_o`  out  5  EX/MEM destination register.
- `stall_o`  out  1  combinational; while high, upstream holds all `*_i` from ID/EX stable.

## Operation
- Forwarding for operand A (uses `RS1addr_i`) and operand B (uses `RS2addr_i`):
  - EX/MEM hit: `RegWrite_o` = 1, `RDaddr_o` ≠ 0, and `RDaddr_o` matches. Value is `ALUResult_o`.
  - MEM/WB hit: `MEMWB_RegWrite_i` = 1, `MEMWB_RDaddr_i` ≠ 0, and `MEMWB_RDaddr_i` matches. Value is `MEMWB_data_i`.
  - Priority: EX/MEM hit, then MEM/WB hit, then the raw `data*_i`.
- Operand B = `ALUSrc_i` ? `imm_i` : forwarded rs2. `MemData_o` always captures forwarded rs2.
- ALU operations, 32-bit, wrap-around, no overflow flags:
  - ALUOp 00: A + B.
  - ALUOp 10, by `funct_i`:
    - 0000000_111: and.
    - 0000000_100: xor.
    - 0000000_001: sll, by B[4:0].
    - 0000000_000: add.
    - 0100000_000: sub.
    - 0000001_000: mul, which is multi-cycle.
  - ALUOp 11, by `funct_i[2:0]`:
    - 000: addi.
    - 101: srai (arithmetic shift right by `imm_i[4:0]`).
  - Any other code: result 0, control passed through unchanged.
- Multiply FSM, states IDLE, BUSY, DONE:
  - IDLE with mul present (ALUOp 10, funct 0000001_000): latch forwarded A and B, clear accumulator, count = 0, go to BUSY. `stall_o` = 1 this cycle.
  - BUSY: each cycle, acc += (A × B[8·count+7 : 8·count]) << 8·count, keeping the low 32 bits; count++.
    - After the count = 3 update, go to DONE.
    - `stall_o` = 1.
  - DONE: `stall_o` = 0. EX/MEM captures acc plus the mul's control bits and RDaddr. Next state is IDLE.
  - Result is the low 32 bits of the product; signedness is irrelevant.
- EX/MEM capture:
  - Every cycle with `stall_o` = 0, capture the result, forwarded rs2, `RDaddr_i` and the four control bits.
  - Every cycle with `stall_o` = 1, capture a bubble: all four control bits 0, data and address 0.

## Timing
- Reset (`rst_i` low, asynchronous): all outputs 0, FSM in IDLE, count and acc 0. `stall_o` is 0 while reset is asserted.
- Reset asserted mid-multiply aborts it. No result is written, and the held mul is re-detected after release.
- Non-mul latency: 1 cycle from ID/EX output to EX/MEM output.
- mul latency: 6 cycles in EX (IDLE detect, 4 × BUSY, DONE). `stall_o` is high for exactly 5 consecutive cycles and the result appears at the 6th edge.
- Back-to-back mul: DONE goes to IDLE, so the next mul is detected on the following cycle with no lost cycle beyond the 6.
- Operands are sampled only at detect, so forwarding sources changing during BUSY have no effect.
- A bubble from ID/EX (all control bits 0, ALUOp 00) never triggers the FSM.

## Test plan
- Reset: drive `rst_i` low mid-cycle -> all outputs 0 immediately, `stall_o` = 0.
- add x3, x1, x2 with `data1_i` = 5, `data2_i` = 7 -> next edge `ALUResult_o` = 12, `RDaddr_o` = 3, `RegWrite_o` = 1.
- Forward priority:
  - Prior EX/MEM wrote x1 = 100 and MEM/WB writes x1 = 50; sub x4, x1, x2 with x2 = 1 -> 99.
  - Repeat with EX/MEM `RDaddr_o` = 0 -> 49.
- mul x5, x6, x7 with 0x00012345 × 0x00000100 -> `stall_o` high 5 cycles, EX/MEM bubbles meanwhile, `ALUResult_o` = 0x01234500 on the 6th edge.
- Assert reset during BUSY cycle 2 -> FSM IDLE and outputs 0. After release, the held mul completes in 6 cycles with the correct product.
- Immediates:
  - srai with `imm_i` = 0x404 (shamt 4), A = 0x80000000 -> 0xF8000000.
  - addi with `imm_i` = 0xFFFFFFFF, A = 0 -> 0xFFFFFFFF.
  - sw: ALUOp 00, ALUSrc = 1, `data2_i` = 0xAB -> `MemData_o` = 0xAB, `MemWrite_o` = 1.
